// File: rtl/fetch_decode_latch.sv
// Fetch-to-decode boundary: tracks the single outstanding instruction fetch, buffers a completed
// fetch while decode stalls, drains responses orphaned by a flush and holds the decode entry.
package fetch_decode_latch_pkg;
  typedef struct packed {
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module fetch_decode_latch
  import fetch_decode_latch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PCD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        stallD,
  input  logic        reqF,
  input  logic [31:0] pcF,
  input  logic        inslotF,
  input  logic        AddrErrorF,
  input  logic [31:0] BadVaddrF,
  input  ibus_resp_t  iresp,
  output logic        stallF,
  output logic        validD,
  output logic [31:0] pcD,
  output logic [31:0] instrD,
  output logic        inslotD,
  output logic        AddrErrorD,
  output logic [31:0] BadVaddrD
);

  typedef enum logic [1:0] {StIdle, StWait, StBuf, StDrop} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic [31:0] pend_pc_q;
  logic        pend_inslot_q;
  logic        pend_load;

  logic [31:0] buf_pc_q, buf_instr_q, buf_badva_q;
  logic        buf_inslot_q, buf_aerr_q;
  logic        buf_load;

  // Entry completing this cycle (or replayed from the buffer)
  logic        rdy_valid;
  logic [31:0] rdy_pc, rdy_instr, rdy_badva;
  logic        rdy_inslot, rdy_aerr;

  assign accept = ~stallD & ~flush;
  assign stallF = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    pend_load  = 1'b0;
    buf_load   = 1'b0;
    rdy_valid  = 1'b0;
    rdy_pc     = pend_pc_q;
    rdy_instr  = NOP_INSTR;
    rdy_inslot = pend_inslot_q;
    rdy_aerr   = 1'b0;
    rdy_badva  = '0;
    unique case (state_q)
      StIdle: begin
        if (reqF) begin
          if (!AddrErrorF) begin
            // The bus request is already out, so a flush must still drain its response.
            if (flush) begin
              state_d = StDrop;
            end else begin
              state_d   = StWait;
              pend_load = 1'b1;
            end
          end else if (!flush) begin
            rdy_valid  = 1'b1;
            rdy_pc     = pcF;
            rdy_inslot = inslotF;
            rdy_aerr   = 1'b1;
            rdy_badva  = BadVaddrF;
            if (!accept) begin
              buf_load = 1'b1;
              state_d  = StBuf;
            end
          end
        end
      end
      StWait: begin
        if (iresp.data_ok) begin
          state_d = StIdle;
          if (!flush) begin
            rdy_valid = 1'b1;
            rdy_instr = iresp.data;
            if (!accept) begin
              buf_load = 1'b1;
              state_d  = StBuf;
            end
          end
        end else if (flush) begin
          state_d = StDrop;
        end
      end
      StBuf: begin
        rdy_valid  = 1'b1;
        rdy_pc     = buf_pc_q;
        rdy_instr  = buf_instr_q;
        rdy_inslot = buf_inslot_q;
        rdy_aerr   = buf_aerr_q;
        rdy_badva  = buf_badva_q;
        if (accept || flush) begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (iresp.data_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= StIdle;
      pend_pc_q     <= '0;
      pend_inslot_q <= 1'b0;
      buf_pc_q      <= '0;
      buf_instr_q   <= '0;
      buf_inslot_q  <= 1'b0;
      buf_aerr_q    <= 1'b0;
      buf_badva_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pend_load) begin
        pend_pc_q     <= pcF;
        pend_inslot_q <= inslotF;
      end
      if (buf_load) begin
        buf_pc_q     <= rdy_pc;
        buf_instr_q  <= rdy_instr;
        buf_inslot_q <= rdy_inslot;
        buf_aerr_q   <= rdy_aerr;
        buf_badva_q  <= rdy_badva;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      validD     <= 1'b0;
      pcD        <= RESET_PCD;
      instrD     <= NOP_INSTR;
      inslotD    <= 1'b0;
      AddrErrorD <= 1'b0;
      BadVaddrD  <= '0;
    end else if (flush) begin
      validD <= 1'b0;
    end else if (!stallD) begin
      validD <= rdy_valid;
      if (rdy_valid) begin
        pcD        <= rdy_pc;
        instrD     <= rdy_instr;
        inslotD    <= rdy_inslot;
        AddrErrorD <= rdy_aerr;
        BadVaddrD  <= rdy_badva;
      end
    end
  end

endmodule

// File: tb/tb_fetch_decode_latch.sv
// Scoreboard bench for fetch_decode_latch: directed fetch scenarios push expected decode entries,
// a monitor pops and compares each entry newly loaded into the D register.
module tb_fetch_decode_latch;
  import fetch_decode_latch_pkg::*;

  localparam logic [31:0] Nop   = 32'h0000_0000;
  localparam logic [31:0] RstPc = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        inslot;
    logic        aerr;
    logic [31:0] badva;
  } entry_t;

  logic        clk = 1'b0;
  logic        resetn, flush, stallD, reqF, inslotF, AddrErrorF;
  logic [31:0] pcF, BadVaddrF;
  ibus_resp_t  iresp;
  logic        stallF, validD, inslotD, AddrErrorD;
  logic [31:0] pcD, instrD, BadVaddrD;

  int     n_vec = 0;
  int     n_bad = 0;
  entry_t exp_q[$];
  logic   ld_q = 1'b0;

  fetch_decode_latch #(.NOP_INSTR(Nop), .RESET_PCD(RstPc)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .stallD    (stallD),
    .reqF      (reqF),
    .pcF       (pcF),
    .inslotF   (inslotF),
    .AddrErrorF(AddrErrorF),
    .BadVaddrF (BadVaddrF),
    .iresp     (iresp),
    .stallF    (stallF),
    .validD    (validD),
    .pcD       (pcD),
    .instrD    (instrD),
    .inslotD   (inslotD),
    .AddrErrorD(AddrErrorD),
    .BadVaddrD (BadVaddrD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // A D load happens only on an edge where decode was neither stalled nor flushed.
  always @(posedge clk) ld_q <= resetn & ~stallD & ~flush;

  always @(negedge clk) begin
    if (ld_q && validD) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_entry: got pc=%h instr=%h, expected no entry", pcD, instrD);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("entry_pc", pcD, e.pc);
        chk("entry_instr", instrD, e.instr);
        chk("entry_inslot", {31'd0, inslotD}, {31'd0, e.inslot});
        chk("entry_aerr", {31'd0, AddrErrorD}, {31'd0, e.aerr});
        chk("entry_badva", BadVaddrD, e.badva);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; stallD = 1'b0; reqF = 1'b0; inslotF = 1'b0;
    AddrErrorF = 1'b0; pcF = '0; BadVaddrF = '0; iresp = '0;
    step(); step();
    resetn = 1'b1;
    chk("rst_validD", {31'd0, validD}, 32'd0);
    chk("rst_pcD", pcD, RstPc);
    chk("rst_instrD", instrD, Nop);
    chk("rst_stallF", {31'd0, stallF}, 32'd0);
    chk("rst_aerr", {31'd0, AddrErrorD}, 32'd0);

    // Basic fetch, response two cycles after the request
    step(); reqF = 1'b1; pcF = 32'hbfc0_0000;
    exp_q.push_back('{32'hbfc0_0000, 32'h2408_0001, 1'b0, 1'b0, 32'd0});
    step(); reqF = 1'b0;
    chk("basic_stallF_wait", {31'd0, stallF}, 32'd1);
    step(); iresp = '{1'b1, 32'h2408_0001};
    chk("basic_stallF_wait2", {31'd0, stallF}, 32'd1);
    step(); iresp = '0;
    chk("basic_validD", {31'd0, validD}, 32'd1);
    chk("basic_stallF_idle", {31'd0, stallF}, 32'd0);
    step();
    chk("basic_bubble", {31'd0, validD}, 32'd0);

    // Stall across data_ok: entry parks in the buffer
    reqF = 1'b1; pcF = 32'hbfc0_0008; inslotF = 1'b1;
    exp_q.push_back('{32'hbfc0_0008, 32'h2408_0001, 1'b1, 1'b0, 32'd0});
    step(); reqF = 1'b0; inslotF = 1'b0; stallD = 1'b1;
    step(); iresp = '{1'b1, 32'h2408_0001};
    step(); iresp = '0;
    chk("stall_stallF_buf", {31'd0, stallF}, 32'd1);
    chk("stall_validD_hold", {31'd0, validD}, 32'd0);
    chk("stall_pcD_hold", pcD, 32'hbfc0_0000);
    step(); stallD = 1'b0;
    step();
    chk("stall_stallF_idle", {31'd0, stallF}, 32'd0);
    chk("stall_validD", {31'd0, validD}, 32'd1);
    step();

    // Flush while the fetch is in flight: response drained and dropped
    reqF = 1'b1; pcF = 32'hbfc0_0004;
    step(); reqF = 1'b0; flush = 1'b1;
    step(); flush = 1'b0;
    step(); iresp = '{1'b1, 32'hdead_beef};
    chk("flush_stallF_drop", {31'd0, stallF}, 32'd1);
    step(); iresp = '0;
    chk("flush_stallF_idle", {31'd0, stallF}, 32'd0);
    chk("flush_validD", {31'd0, validD}, 32'd0);
    chk("flush_instrD_kept", instrD, 32'h2408_0001);
    step();

    // Address error, decode free
    reqF = 1'b1; AddrErrorF = 1'b1; pcF = 32'hbfc0_0002; BadVaddrF = 32'hbfc0_0002;
    exp_q.push_back('{32'hbfc0_0002, Nop, 1'b0, 1'b1, 32'hbfc0_0002});
    chk("aerr_stallF_pre", {31'd0, stallF}, 32'd0);
    step(); reqF = 1'b0; AddrErrorF = 1'b0; BadVaddrF = '0;
    chk("aerr_stallF", {31'd0, stallF}, 32'd0);
    chk("aerr_validD", {31'd0, validD}, 32'd1);
    step();

    // Address error while decode stalled: goes through the buffer
    reqF = 1'b1; AddrErrorF = 1'b1; pcF = 32'hbfc0_0014; BadVaddrF = 32'hbfc0_0015; stallD = 1'b1;
    exp_q.push_back('{32'hbfc0_0014, Nop, 1'b0, 1'b1, 32'hbfc0_0015});
    step(); reqF = 1'b0; AddrErrorF = 1'b0; BadVaddrF = '0;
    chk("aerrbuf_stallF", {31'd0, stallF}, 32'd1);
    chk("aerrbuf_validD", {31'd0, validD}, 32'd0);
    step(); stallD = 1'b0;
    step();
    chk("aerrbuf_stallF_idle", {31'd0, stallF}, 32'd0);
    step();

    // Flush coincident with data_ok in WAIT, then an immediate new request
    reqF = 1'b1; pcF = 32'hbfc0_000c;
    step(); reqF = 1'b0;
    step(); iresp = '{1'b1, 32'h1111_2222}; flush = 1'b1;
    step(); iresp = '0; flush = 1'b0; reqF = 1'b1; pcF = 32'hbfc0_0010;
    chk("fdok_validD", {31'd0, validD}, 32'd0);
    chk("fdok_stallF", {31'd0, stallF}, 32'd0);
    exp_q.push_back('{32'hbfc0_0010, 32'h2222_3333, 1'b0, 1'b0, 32'd0});
    step(); reqF = 1'b0;
    chk("fdok_new_wait", {31'd0, stallF}, 32'd1);
    step(); iresp = '{1'b1, 32'h2222_3333};
    step(); iresp = '0;
    step();

    // Reset while WAIT, response arrives afterwards
    reqF = 1'b1; pcF = 32'hbfc0_0018; inslotF = 1'b1;
    step(); reqF = 1'b0; inslotF = 1'b0; resetn = 1'b0;
    step(); resetn = 1'b1; iresp = '{1'b1, 32'haaaa_5555};
    step(); iresp = '0;
    chk("rstw_validD", {31'd0, validD}, 32'd0);
    chk("rstw_stallF", {31'd0, stallF}, 32'd0);
    chk("rstw_pcD", pcD, RstPc);
    chk("rstw_instrD", instrD, Nop);
    chk("rstw_badva", BadVaddrD, 32'd0);
    step();
    chk("rstw_validD_later", {31'd0, validD}, 32'd0);
    step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_latch.md
Name: fetch_decode_latch

Overview:
Fetch-to-decode boundary stage for the MIPS pipeline. It tracks the single outstanding instruction-bus fetch issued by the fetch stage and pairs the returned instruction word with its PC, delay-slot flag and address-error information. It buffers a completed fetch while decode is stalled and drains responses orphaned by a flush. It presents one registered decode-stage entry and back-pressures fetch with stallF.

Parameters:
NOP_INSTR, 32'h0000_0000, instruction word driven for address-error entries and for bubbles.
RESET_PCD, 32'h0000_0000, reset value of pcD.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
flush  in  1  pipeline flush (exception or redirect); kills the D entry and any in-flight or buffered fetch
stallD  in  1  decode stalled; D register holds
reqF  in  1  fetch issued a bus request this cycle (mirrors ireq.valid, or a suppressed request with AddrErrorF=1)
pcF  in  32  PC of the fetch issued this cycle
inslotF  in  1  fetched instruction is a branch delay slot
AddrErrorF  in  1  misaligned fetch address; no bus transaction issued
BadVaddrF  in  32  faulting address when AddrErrorF=1
iresp  in  ibus_resp_t  bus response; only data_ok and data are used
stallF  out  1  fetch must hold pcF and must not assert reqF
validD  out  1  D entry valid
pcD  out  32  PC of D entry
instrD  out  32  instruction of D entry
inslotD  out  1  delay-slot flag of D entry
AddrErrorD  out  1  D entry carries an instruction address error
BadVaddrD  out  32  faulting address of D entry

Behaviour:
Reset (resetn=0 at posedge):
- state=IDLE; validD=0; pcD=RESET_PCD; instrD=NOP_INSTR.
- inslotD=0; AddrErrorD=0; BadVaddrD=0; pending/buffer contents cleared.
- Reset overrides flush and all in-flight activity. A bus response arriving after reset is ignored because state is IDLE.

stallF is combinational: stallF = (state != IDLE). reqF is sampled only in IDLE.

Definitions:
- accept = ~stallD & ~flush.
- "Ready entry" = an entry that completes this cycle, or the entry held in the buffer.

States and transitions:
- IDLE
  - reqF & ~AddrErrorF & ~flush: latch {pcF, inslotF} into pend; go to WAIT.
  - reqF & ~AddrErrorF & flush: go to DROP, since the bus request was already issued.
  - reqF & AddrErrorF & ~flush: ready entry {pcF, NOP_INSTR, inslotF, AddrError=1, BadVaddrF}. If accept, load it into D and stay in IDLE; otherwise store it in the buffer and go to BUF.
  - reqF & AddrErrorF & flush: entry discarded; stay in IDLE.
- WAIT
  - data_ok & ~flush: ready entry {pend, iresp.data, AddrError=0, BadVaddr=0}. If accept, load D and go to IDLE; otherwise buffer it and go to BUF.
  - data_ok & flush: discard; go to IDLE.
  - ~data_ok & flush: go to DROP.
- BUF
  - accept: load D from the buffer; go to IDLE.
  - flush: discard the buffer; go to IDLE.
  - Otherwise hold.
- DROP
  - data_ok: discard the data; go to IDLE. A flush in DROP has no additional effect.

D register, priority in this order:
1. flush: validD<=0; other D fields are don't-care but hold their values.
2. stallD: all D fields hold.
3. ~stallD with a ready entry: load the entry; validD<=1.
4. ~stallD with no ready entry: validD<=0 (bubble); other D fields hold.

Latency and ordering:
- Best case: data_ok in cycle N gives validD=1 from cycle N+1 (response bypasses the buffer).
- At most one outstanding fetch. Responses are in order, so no ID matching is needed.

Test Plan:
- Basic fetch: reqF=1, pcF=32'hbfc0_0000 in IDLE; data_ok=1, data=32'h2408_0001 two cycles later -> stallF=1 during WAIT; the next cycle validD=1, pcD=32'hbfc0_0000, instrD=32'h2408_0001, stallF=0.
- Stall buffering: same fetch, stallD=1 for 3 cycles spanning data_ok -> state BUF, validD and D fields unchanged; on stallD=0, D loads 32'h2408_0001 the following cycle, then state returns to IDLE.
- Flush in flight: reqF at pcF=32'hbfc0_0004, flush asserted one cycle later, data_ok=1 with data=32'hdead_beef two cycles after that -> validD=0; instrD never becomes 32'hdead_beef; stallF drops the cycle after data_ok.
- Address error: reqF=1, AddrErrorF=1, pcF=BadVaddrF=32'hbfc0_0002, stallD=0 -> the next cycle validD=1, AddrErrorD=1, BadVaddrD=32'hbfc0_0002, instrD=0, stallF stays 0.
- Simultaneous flush and data_ok in WAIT -> response discarded, state IDLE, validD=0 the next cycle; a new reqF is accepted immediately.
- Reset mid-WAIT: resetn=0 for one cycle, then data_ok arrives -> all outputs at reset values, validD stays 0, stallF=0.
